seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; generalises the team's fixed 2-bit-state FSM (registered Mealy output) to an arbitrary WIDTH-bit pattern.
- Adds a selectable overlap mode, an input-valid qualifier, and a saturating match counter.
- Sits on a serial bit stream and flags each pattern occurrence one cycle after the completing bit.
- Same structure as the existing FSM: next-state/output logic followed by a registered state and output.

Parameters:
- WIDTH, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern to detect; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, history restarts empty.
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in; the detector advances only when high.
- in  input  1  serial data bit.
- cnt_clr  input  1  synchronous clear of match_cnt.
- out  output  1  one-cycle match pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.
- armed  output  1  high when fill == WIDTH, i.e. the history is full.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: hist=0, fill=0, out=0, match_cnt=0, armed=0. The pattern register resets to PATTERN.
- State: hist[WIDTH-1:0] holds the last bits received. fill counts valid bits held, 0..WIDTH.
- FSM view:
  - FILL: fill < WIDTH.
  - ARMED: fill == WIDTH.
  - FILL -> ARMED when fill reaches WIDTH.
  - ARMED -> FILL only on reset, or on a match when OVERLAP=0.
- Per edge with in_valid=1:
  - nh = {hist[WIDTH-2:0], in}; hist <= nh.
  - match = (fill >= WIDTH-1) && (nh == pattern).
  - out <= match.
  - On match, match_cnt increments, saturating at 2^CNT_W-1.
- Fill update on a match:
  - OVERLAP=1: fill <= WIDTH.
  - OVERLAP=0: fill <= 0 and hist <= 0.
- Fill update with no match: fill <= min(fill+1, WIDTH).
- in_valid=0: hist and fill hold, out <= 0, match_cnt holds.
- Latency: out is high for exactly the one cycle following the edge that sampled the final pattern bit.
- cnt_clr: match_cnt <= 0. If cnt_clr and a match occur on the same edge, match_cnt <= 0 (clear wins). out still pulses.
- Reset priority: rst beats all other inputs. Reset mid-pattern discards partial history; WIDTH fresh valid bits are needed before the next match.
- Counter saturation: at all-ones, further matches leave match_cnt unchanged; out still pulses.
- armed = (fill == WIDTH), registered-state derived.

Optional Feature:
- Macro: SEQDET_PROG_EN.
- When defined, two extra ports:
  - pat_load  input  1
  - pat_in  input  WIDTH
- pat_load=1 on an edge:
  - pattern register <= pat_in; fill <= 0; hist <= 0; out <= 0.
  - in is ignored that cycle; match_cnt is unaffected.
- rst has priority over pat_load.
- When undefined: the ports do not exist, and pattern is the constant PATTERN.

Test Plan:
- WIDTH=4, PATTERN=1011, OVERLAP=1; rst, then valid bits 1,0,1,1,0,1,1 -> out pulses the cycle after bit 4 and after bit 7; match_cnt=2.
- Same stream, OVERLAP=0 -> single pulse after bit 4; match_cnt=1; armed drops to 0 the cycle after the match.
- Bits 1,0 then in_valid=0 for 3 cycles, then 1,1 -> hist holds during the gap; pulse after the final 1; out=0 during the gap.
- Bits 1,0,1, then rst, then 1 -> no pulse; after reset, 1,0,1,1 -> pulse; match_cnt=1.
- CNT_W=2, five matches with OVERLAP=1 -> match_cnt sequence 1,2,3,3,3. Then cnt_clr together with a 6th match -> match_cnt=0, out=1.
- SEQDET_PROG_EN: pat_load with pat_in=0110, then bits 0,1,1,0 -> pulse; bits 1,0,1,1 -> no pulse.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with registered match pulse, overlap mode,
// input-valid qualifier and saturating match counter. Optional SEQDET_PROG_EN adds a loadable pattern.
//
// state | meaning
// FILL  | fewer than WIDTH valid bits held in hist (fill < WIDTH)
// ARMED | history full (fill == WIDTH); a match is possible on every valid bit
module seq_detect_param #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cnt_clr,
`ifdef SEQDET_PROG_EN
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_in,
`endif
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);
    localparam logic [FW-1:0] FILL_PRE = FW'(WIDTH - 1);

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pattern;
    logic             load;
    logic [WIDTH-1:0] nh;
    logic             match;

`ifdef SEQDET_PROG_EN
    logic [WIDTH-1:0] pat_q, pat_d;

    assign load    = pat_load;
    assign pattern = pat_q;

    always_comb begin
        pat_d = pat_q;
        if (pat_load) pat_d = pat_in;
    end

    always_ff @(posedge clk) begin
        if (rst) pat_q <= PATTERN;
        else     pat_q <= pat_d;
    end
`else
    assign load    = 1'b0;
    assign pattern = PATTERN;
`endif

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        cnt_d  = cnt_q;
        nh     = {hist_q[WIDTH-2:0], in};
        match  = 1'b0;

        if (load) begin
            // A new pattern invalidates any partial history.
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            match  = (fill_q >= FILL_PRE) && (nh == pattern);
            hist_d = nh;
            out_d  = match;
            if (match) begin
                if (OVERLAP != 0) begin
                    fill_d = FILL_MAX;
                end else begin
                    fill_d = '0;
                    hist_d = '0;
                end
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end

        if (cnt_clr) cnt_d = '0;

        state_d = (fill_d == FILL_MAX) ? ARMED : FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlap, non-overlap and 2-bit counter instances share stimulus.
// Exercises the SEQDET_PROG_EN pattern load when that macro is defined.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic cnt_clr = 1'b0;
`ifdef SEQDET_PROG_EN
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
`endif

    logic       out_ov, arm_ov;
    logic [7:0] cnt_ov;
    logic       out_nov, arm_nov;
    logic [7:0] cnt_nov;
    logic       out_c2, arm_c2;
    logic [1:0] cnt_c2;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
`ifdef SEQDET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .out(out_ov), .match_cnt(cnt_ov), .armed(arm_ov)
    );

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
`ifdef SEQDET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .out(out_nov), .match_cnt(cnt_nov), .armed(arm_nov)
    );

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cnt_clr(cnt_clr),
`ifdef SEQDET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .out(out_c2), .match_cnt(cnt_c2), .armed(arm_c2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        in       = b;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted alongside a valid 1 to show it overrides the data path.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 1'b1;
        cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int bits7[7]  = '{1, 0, 1, 1, 0, 1, 1};
    int e_ov[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int e_nov[7]  = '{0, 0, 0, 1, 0, 0, 0};
    int e_arm[7]  = '{0, 0, 0, 1, 1, 1, 1};
    int e_c2[4]   = '{2, 3, 3, 3};

    initial begin
        // Reset state
        do_reset();
        check("rst_out", 32'(out_ov), 0);
        check("rst_cnt", 32'(cnt_ov), 0);
        check("rst_armed", 32'(arm_ov), 0);

        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits7[i][0], 1'b0);
            check($sformatf("ov_out_b%0d", i + 1), 32'(out_ov), 32'(e_ov[i]));
            check($sformatf("nov_out_b%0d", i + 1), 32'(out_nov), 32'(e_nov[i]));
            check($sformatf("ov_armed_b%0d", i + 1), 32'(arm_ov), 32'(e_arm[i]));
            if (i == 3) check("nov_armed_after_match", 32'(arm_nov), 0);
        end
        check("ov_cnt", 32'(cnt_ov), 2);
        check("nov_cnt", 32'(cnt_nov), 1);

        // Valid gap: history holds, out low during the gap
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("gap_out_%0d", i), 32'(out_ov), 0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("gap_out_b3", 32'(out_ov), 0);
        step(1'b1, 1'b1, 1'b0);
        check("gap_out_b4", 32'(out_ov), 1);
        check("gap_armed", 32'(arm_ov), 1);

        // Reset mid-pattern discards partial history
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        check("midrst_armed", 32'(arm_ov), 0);
        step(1'b1, 1'b1, 1'b0);
        check("midrst_out_first", 32'(out_ov), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midrst_out_b3", 32'(out_ov), 0);
        step(1'b1, 1'b1, 1'b0);
        check("midrst_out_b4", 32'(out_ov), 1);
        check("midrst_cnt", 32'(cnt_ov), 1);

        // 2-bit counter saturation, then clear racing a match
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("c2_cnt_m1", 32'(cnt_c2), 1);
        for (int m = 0; m < 4; m++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("c2_out_m%0d", m + 2), 32'(out_c2), 1);
            check($sformatf("c2_cnt_m%0d", m + 2), 32'(cnt_c2), 32'(e_c2[m]));
        end
        check("ov_cnt_m5", 32'(cnt_ov), 5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr_match_cnt", 32'(cnt_c2), 0);
        check("clr_match_out", 32'(out_c2), 1);
        check("clr_match_cnt_ov", 32'(cnt_ov), 0);

`ifdef SEQDET_PROG_EN
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_load_cnt", 32'(cnt_ov), 1);
        @(negedge clk);
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        in_valid = 1'b1;
        in       = 1'b1;
        @(posedge clk);
        #1;
        check("load_out", 32'(out_ov), 0);
        check("load_armed", 32'(arm_ov), 0);
        check("load_cnt", 32'(cnt_ov), 1);
        @(negedge clk);
        pat_load = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("prog_out_b3", 32'(out_ov), 0);
        step(1'b1, 1'b0, 1'b0);
        check("prog_out_b4", 32'(out_ov), 1);
        step(1'b1, 1'b1, 1'b0);
        check("prog_old_b1", 32'(out_ov), 0);
        step(1'b1, 1'b0, 1'b0);
        check("prog_old_b2", 32'(out_ov), 0);
        step(1'b1, 1'b1, 1'b0);
        check("prog_old_b3", 32'(out_ov), 0);
        step(1'b1, 1'b1, 1'b0);
        check("prog_old_b4", 32'(out_ov), 0);
        check("prog_cnt", 32'(cnt_ov), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
